// File: rtl/dm_access_sequencer.sv
// Data-memory access sequencer: maps byte-addressed loads/stores onto a word-only synchronous RAM,
// using read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
module dm_access_sequencer #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [2:0]            op,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  stall,
  output logic                  misalign,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  // Access codes mirror the core's DM_OP encoding.
  localparam logic [2:0] OP_WD = 3'd0;
  localparam logic [2:0] OP_SB = 3'd1;
  localparam logic [2:0] OP_SH = 3'd2;
  localparam logic [2:0] OP_UB = 3'd3;
  localparam logic [2:0] OP_UH = 3'd4;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RMW = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [1:0]            off_q, off_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mis_s;
  logic [31:0]           load_val_s;
  logic [31:0]           merge_val_s;

  function automatic logic [31:0] extend_lane(input logic [2:0] o, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (o)
      OP_SB:   extend_lane = {{24{b[7]}}, b};
      OP_UB:   extend_lane = {24'd0, b};
      OP_SH:   extend_lane = {{16{h[15]}}, h};
      OP_UH:   extend_lane = {16'd0, h};
      default: extend_lane = w;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [2:0] o, input logic [1:0] off,
                                             input logic [31:0] old, input logic [31:0] nw);
    logic [31:0] m;
    m = old;
    case (o)
      OP_SB, OP_UB: m[8*off +: 8] = nw[7:0];
      OP_SH, OP_UH: m[16*off[1] +: 16] = nw[15:0];
      default:      m = old;
    endcase
    return m;
  endfunction

  always_comb begin
    case (op)
      OP_WD:        mis_s = (addr[1:0] != 2'd0);
      OP_SH, OP_UH: mis_s = addr[0];
      default:      mis_s = 1'b0;
    endcase
  end

  assign load_val_s  = extend_lane(op_q, off_q, ram_rdata);
  assign merge_val_s = merge_lane(op_q, off_q, ram_rdata, wdata_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      off_q   <= 2'd0;
      waddr_q <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req && !mis_s && (!we || op != OP_WD)) begin
          op_d    = op;
          off_d   = addr[1:0];
          waddr_d = addr[ADDR_WIDTH+1:2];
          wdata_d = wdata;
          state_d = we ? RMW : LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        rdata_d = load_val_s;
        state_d = IDLE;
      end
      RMW:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced to their idle values while rst is high so an interrupted RMW never writes.
  always_comb begin
    stall     = 1'b0;
    misalign  = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = 32'd0;
    ram_addr  = addr[ADDR_WIDTH+1:2];
    rdata     = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (mis_s) begin
            misalign = 1'b1;
          end else if (we && op == OP_WD) begin
            ram_we    = 1'b1;
            ram_wdata = wdata;
          end else begin
            stall = 1'b1;
          end
        end else begin
          stall = 1'b0;
        end
      end
      LOAD: begin
        ram_addr = waddr_q;
        rdata    = load_val_s;
      end
      RMW: begin
        ram_addr  = waddr_q;
        ram_we    = 1'b1;
        ram_wdata = merge_val_s;
      end
      default: ram_addr = waddr_q;
    endcase
    if (rst) begin
      stall     = 1'b0;
      misalign  = 1'b0;
      ram_we    = 1'b0;
      ram_wdata = 32'd0;
      ram_addr  = '0;
      rdata     = 32'd0;
    end else begin
      rdata = rdata;
    end
  end

endmodule

// File: tb/tb_dm_access_sequencer.sv
// Scoreboard bench for dm_access_sequencer: directed accesses against a write-first RAM model.
module tb_dm_access_sequencer;
  localparam int AW = 10;
  localparam logic [2:0] OP_WD = 3'd0;
  localparam logic [2:0] OP_SB = 3'd1;
  localparam logic [2:0] OP_SH = 3'd2;
  localparam logic [2:0] OP_UB = 3'd3;
  localparam logic [2:0] OP_UH = 3'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [2:0]    op;
  logic          we;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          stall;
  logic          misalign;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic [31:0]   mem [0:(1<<AW)-1];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] ld_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        prev_stall = 1'b0;

  dm_access_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .misalign(misalign), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Write-first synchronous RAM; content is not affected by rst.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      ram_rdata     <= ram_wdata;
    end else begin
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a RAM write pops the write queue, a stall falling without a write pops the load queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (ram_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("write_addr", {22'd0, ram_addr}, {22'd0, e.a});
          chk("write_data", ram_wdata, e.d);
        end
      end else if (prev_stall && !stall) begin
        if (ld_q.size() == 0) begin
          chk("unexpected_load", 32'd1, 32'd0);
        end else begin
          chk("load_rdata", rdata, ld_q.pop_front());
        end
      end
      prev_stall <= stall;
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic do_sw(input logic [31:0] a, input logic [31:0] d, input logic [AW-1:0] wa);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; op = OP_WD; addr = a; wdata = d;
    wr_q.push_back('{a: wa, d: d});
    @(negedge clk);
    chk("sw_stall", {31'd0, stall}, 32'd0);
    chk("sw_ram_we", {31'd0, ram_we}, 32'd1);
  endtask

  task automatic do_sub_store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                              input logic [AW-1:0] wa, input logic [31:0] exp_word);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; op = o; addr = a; wdata = d;
    wr_q.push_back('{a: wa, d: exp_word});
    @(negedge clk);
    chk("rmw_c1_stall", {31'd0, stall}, 32'd1);
    chk("rmw_c1_ram_we", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    chk("rmw_c2_stall", {31'd0, stall}, 32'd0);
  endtask

  task automatic do_load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; op = o; addr = a;
    ld_q.push_back(exp);
    @(negedge clk);
    chk("ld_c1_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    chk("ld_c2_stall", {31'd0, stall}, 32'd0);
  endtask

  task automatic do_misaligned(input logic [2:0] o, input logic [31:0] a, input logic w,
                               input logic [31:0] last);
    @(posedge clk); #1;
    req = 1'b1; we = w; op = o; addr = a; wdata = 32'h5555_5555;
    @(negedge clk);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    chk("mis_ram_we", {31'd0, ram_we}, 32'd0);
    chk("mis_rdata", rdata, last);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
    rst = 1'b1; req = 1'b1; op = OP_WD; we = 1'b1; addr = 32'h0000_0123; wdata = 32'h1;
    #12;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_misalign", {31'd0, misalign}, 32'd0);

    do_sw(32'h0000_0010, 32'hDEAD_BEEF, 10'd4);
    chk("sw_ram_addr", {22'd0, ram_addr}, 32'd4);
    do_sub_store(OP_SB, 32'h0000_0011, 32'h0000_00A5, 10'd4, 32'hDEAD_A5EF);
    do_load(OP_SB, 32'h0000_0011, 32'hFFFF_FFA5);
    do_load(OP_UB, 32'h0000_0011, 32'h0000_00A5);
    do_load(OP_SH, 32'h0000_0012, 32'hFFFF_DEAD);
    idle_cycle();
    @(negedge clk);
    chk("hold_rdata", rdata, 32'hFFFF_DEAD);
    do_misaligned(OP_SH, 32'h0000_0013, 1'b0, 32'hFFFF_DEAD);
    do_misaligned(OP_WD, 32'h0000_0012, 1'b0, 32'hFFFF_DEAD);
    do_misaligned(OP_WD, 32'h0000_0011, 1'b1, 32'hFFFF_DEAD);

    // sh interrupted by reset while in RMW: no write may reach the RAM.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; op = OP_SH; addr = 32'h0000_0010; wdata = 32'h0000_1234;
    @(negedge clk);
    chk("rst_rmw_c1_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rmw_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_rmw_stall", {31'd0, stall}, 32'd0);
    chk("rst_rmw_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    do_load(OP_WD, 32'h0000_0010, 32'hDEAD_A5EF);

    // Back-to-back sb then lw with no gap cycle.
    do_sub_store(OP_SB, 32'h0000_0010, 32'h0000_0077, 10'd4, 32'hDEAD_A577);
    do_load(OP_WD, 32'h0000_0010, 32'hDEAD_A577);

    // Upper address bits wrap; halfword stores/loads in the upper lane.
    do_sw(32'hFFFF_F020, 32'h1122_3344, 10'd8);
    chk("wrap_ram_addr", {22'd0, ram_addr}, 32'd8);
    do_sub_store(OP_UH, 32'h0000_0022, 32'h0000_CAFE, 10'd8, 32'hCAFE_3344);
    do_load(OP_UH, 32'h0000_1022, 32'h0000_CAFE);
    do_load(OP_SH, 32'h0000_0022, 32'hFFFF_CAFE);
    do_sub_store(OP_UB, 32'h0000_0023, 32'h0000_0099, 10'd8, 32'h99FE_3344);
    do_load(OP_UB, 32'h0000_0020, 32'h0000_0044);
    do_load(OP_WD, 32'h0000_0020, 32'h99FE_3344);
    idle_cycle();
    idle_cycle();
    @(negedge clk);
    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("ld_q_drained", ld_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
